// File: rtl/score_bcd_if.sv
// Score-to-display bus: conversion request from the score logic, BCD and
// 7-segment results back from the converter.
interface score_bcd_if #(
    parameter int SCORE_W = 11
);
    logic [SCORE_W-1:0] value_in;
    logic               load;
    logic               blank_lz;
    logic               busy;
    logic               done;
    logic               ovf;
    logic [15:0]        bcd;
    logic [6:0]         hex0;
    logic [6:0]         hex1;
    logic [6:0]         hex2;
    logic [6:0]         hex3;

    modport master (
        output value_in, load, blank_lz,
        input  busy, done, ovf, bcd, hex0, hex1, hex2, hex3
    );

    modport slave (
        input  value_in, load, blank_lz,
        output busy, done, ovf, bcd, hex0, hex1, hex2, hex3
    );
endinterface

// File: rtl/score_bcd_display.sv
// Sequential binary-to-BCD converter (shift-add-3) driving four active-low
// 7-segment digits with optional leading-zero blanking and 9999 saturation.
module score_bcd_display #(
    parameter int SCORE_W = 11,
    parameter int NDIG    = 4
) (
    input  logic        clk,
    input  logic        rst,
    score_bcd_if.slave  bus
);
    localparam int BCD_W = 4 * NDIG;
    localparam int CNT_W = $clog2(SCORE_W + 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [SCORE_W-1:0] r_shift;
    logic [BCD_W-1:0]   r_scratch;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_blank_flag;
    logic               r_ovf_flag;
    logic [BCD_W-1:0]   r_bcd;
    logic [6:0]         r_hex [NDIG];
    logic               r_ovf;
    logic               r_done;

    logic               w_accept;
    logic               w_shift_en;
    logic               w_finish;
    logic               w_busy;
    logic [BCD_W-1:0]   w_adj;
    logic [NDIG-1:0]    w_blank;
    logic [6:0]         w_seg [NDIG];

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.load) w_state_next = S_SHIFT;
            S_SHIFT: if (r_cnt == CNT_W'(1)) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_accept   = (r_state == S_IDLE) && bus.load;
        w_shift_en = (r_state == S_SHIFT);
        w_finish   = (r_state == S_DONE);
        w_busy     = (r_state != S_IDLE);
    end

    genvar gi;
    generate
        for (gi = 0; gi < NDIG; gi++) begin : g_digit
            assign w_adj[4*gi +: 4] = (r_scratch[4*gi +: 4] >= 4'd5) ?
                                      r_scratch[4*gi +: 4] + 4'd3 : r_scratch[4*gi +: 4];
            // A digit is blanked only when it and every digit above it are zero.
            if (gi == 0) begin : g_ones
                assign w_blank[gi] = 1'b0;
            end else begin : g_upper
                assign w_blank[gi] = r_blank_flag && (r_scratch[BCD_W-1:4*gi] == '0);
            end
            assign w_seg[gi] = r_ovf_flag   ? seg7(4'd9) :
                               w_blank[gi]  ? 7'b1111111 : seg7(r_scratch[4*gi +: 4]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift      <= '0;
            r_scratch    <= '0;
            r_cnt        <= '0;
            r_blank_flag <= 1'b0;
            r_ovf_flag   <= 1'b0;
            r_bcd        <= '0;
            r_ovf        <= 1'b0;
            r_done       <= 1'b0;
            for (int i = 0; i < NDIG; i++) r_hex[i] <= 7'b1000000;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_shift      <= bus.value_in;
                r_scratch    <= '0;
                r_cnt        <= CNT_W'(SCORE_W);
                r_blank_flag <= bus.blank_lz;
                r_ovf_flag   <= (32'(bus.value_in) > 32'd9999);
            end
            if (w_shift_en) begin
                r_scratch <= {w_adj[BCD_W-2:0], r_shift[SCORE_W-1]};
                r_shift   <= {r_shift[SCORE_W-2:0], 1'b0};
                r_cnt     <= r_cnt - 1'b1;
            end
            if (w_finish) begin
                r_bcd  <= r_ovf_flag ? {NDIG{4'h9}} : r_scratch;
                r_ovf  <= r_ovf_flag;
                r_done <= 1'b1;
                for (int i = 0; i < NDIG; i++) r_hex[i] <= w_seg[i];
            end
        end
    end

    assign bus.busy = w_busy;
    assign bus.done = r_done;
    assign bus.ovf  = r_ovf;
    assign bus.bcd  = r_bcd;
    assign bus.hex0 = r_hex[0];
    assign bus.hex1 = r_hex[1];
    assign bus.hex2 = r_hex[2];
    assign bus.hex3 = r_hex[3];
endmodule

// File: tb/tb_score_bcd_display.sv
// Directed vector bench for score_bcd_display: an 11-bit and a 14-bit instance.
module tb_score_bcd_display;
    localparam logic [6:0] SZ  = 7'b1000000;
    localparam logic [6:0] S1  = 7'b1111001;
    localparam logic [6:0] S2  = 7'b0100100;
    localparam logic [6:0] S3  = 7'b0110000;
    localparam logic [6:0] S4  = 7'b0011001;
    localparam logic [6:0] S5  = 7'b0010010;
    localparam logic [6:0] S7  = 7'b1111000;
    localparam logic [6:0] S9  = 7'b0010000;
    localparam logic [6:0] OFF = 7'b1111111;

    typedef struct {
        bit         sel;
        int         val;
        bit         blank;
        logic [15:0] bcd;
        logic [6:0] h3;
        logic [6:0] h2;
        logic [6:0] h1;
        logic [6:0] h0;
        bit         ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    score_bcd_if #(.SCORE_W(11)) a_if();
    score_bcd_if #(.SCORE_W(14)) b_if();

    score_bcd_display #(.SCORE_W(11), .NDIG(4)) dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));
    score_bcd_display #(.SCORE_W(14), .NDIG(4)) dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input bit ld, input int val, input bit blank);
        if (sel) begin
            b_if.load = ld; b_if.value_in = 14'(val); b_if.blank_lz = blank;
        end else begin
            a_if.load = ld; a_if.value_in = 11'(val); a_if.blank_lz = blank;
        end
    endtask

    task automatic get(input bit sel, output logic done, output logic busy, output logic ovf,
                       output logic [15:0] bcd, output logic [6:0] h3, output logic [6:0] h2,
                       output logic [6:0] h1, output logic [6:0] h0);
        if (sel) begin
            done = b_if.done; busy = b_if.busy; ovf = b_if.ovf; bcd = b_if.bcd;
            h3 = b_if.hex3; h2 = b_if.hex2; h1 = b_if.hex1; h0 = b_if.hex0;
        end else begin
            done = a_if.done; busy = a_if.busy; ovf = a_if.ovf; bcd = a_if.bcd;
            h3 = a_if.hex3; h2 = a_if.hex2; h1 = a_if.hex1; h0 = a_if.hex0;
        end
    endtask

    // One conversion; optionally fires extra loads of 999 mid-run and in the DONE cycle.
    task automatic convert(input vec_t v, input bit inject, input string tag);
        int lat, busy_cnt, exp_lat;
        logic done, busy, ovf;
        logic [15:0] bcd;
        logic [6:0] h3, h2, h1, h0;
        exp_lat = v.sel ? 15 : 12;
        @(negedge clk);
        drive(v.sel, 1'b1, v.val, v.blank);
        @(posedge clk); #1;
        drive(v.sel, 1'b0, ~v.val, ~v.blank);
        get(v.sel, done, busy, ovf, bcd, h3, h2, h1, h0);
        chk({tag, ".done_single"}, 32'(done), 32'd0);
        busy_cnt = busy ? 1 : 0;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (inject && (lat == 2 || lat == exp_lat - 1)) drive(v.sel, 1'b1, 999, 1'b0);
            else drive(v.sel, 1'b0, ~v.val, ~v.blank);
            get(v.sel, done, busy, ovf, bcd, h3, h2, h1, h0);
            if (done) break;
            if (busy) busy_cnt++;
        end
        drive(v.sel, 1'b0, ~v.val, ~v.blank);
        chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
        chk({tag, ".bcd"}, 32'(bcd), 32'(v.bcd));
        chk({tag, ".hex3"}, 32'(h3), 32'(v.h3));
        chk({tag, ".hex2"}, 32'(h2), 32'(v.h2));
        chk({tag, ".hex1"}, 32'(h1), 32'(v.h1));
        chk({tag, ".hex0"}, 32'(h0), 32'(v.h0));
        chk({tag, ".ovf"}, 32'(ovf), 32'(v.ovf));
        $display("conv %s sel=%0d val=%0d blank=%0d lat=%0d bcd=%04h ovf=%0d",
                 tag, v.sel, v.val, v.blank, lat, bcd, ovf);
    endtask

    vec_t vecs [9];
    vec_t hv;
    int   seen;

    initial begin
        vecs[0] = '{0, 0,     0, 16'h0000, SZ,  SZ,  SZ,  SZ, 0};
        vecs[1] = '{0, 2047,  0, 16'h2047, S2,  SZ,  S4,  S7, 0};
        vecs[2] = '{0, 7,     1, 16'h0007, OFF, OFF, OFF, S7, 0};
        vecs[3] = '{0, 1005,  1, 16'h1005, S1,  SZ,  SZ,  S5, 0};
        vecs[4] = '{0, 0,     1, 16'h0000, OFF, OFF, OFF, SZ, 0};
        vecs[5] = '{0, 40,    1, 16'h0040, OFF, OFF, S4,  SZ, 0};
        vecs[6] = '{1, 12000, 0, 16'h9999, S9,  S9,  S9,  S9, 1};
        vecs[7] = '{1, 9999,  0, 16'h9999, S9,  S9,  S9,  S9, 0};
        vecs[8] = '{1, 10000, 1, 16'h9999, S9,  S9,  S9,  S9, 1};

        rst = 1'b1;
        drive(1'b0, 1'b0, 0, 1'b0);
        drive(1'b1, 1'b0, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset.busy", 32'(a_if.busy), 32'd0);
        chk("reset.done", 32'(a_if.done), 32'd0);
        chk("reset.ovf", 32'(a_if.ovf), 32'd0);
        chk("reset.bcd", 32'(a_if.bcd), 32'h0);
        chk("reset.hex0", 32'(a_if.hex0), 32'(SZ));
        chk("reset.hex3", 32'(a_if.hex3), 32'(SZ));
        chk("reset.b_bcd", 32'(b_if.bcd), 32'h0);

        for (int i = 0; i < 9; i++) begin
            convert(vecs[i], 1'b0, $sformatf("vec%0d", i));
        end

        hv = '{0, 123, 0, 16'h0123, SZ, S1, S2, S3, 0};
        convert(hv, 1'b1, "ignore_busy_loads");
        hv = '{0, 999, 0, 16'h0999, SZ, S9, S9, S9, 0};
        convert(hv, 1'b0, "load_after_done");

        @(negedge clk);
        drive(1'b0, 1'b1, 1500, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 0, 1'b0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("abort.busy", 32'(a_if.busy), 32'd0);
        chk("abort.done", 32'(a_if.done), 32'd0);
        chk("abort.bcd", 32'(a_if.bcd), 32'h0);
        chk("abort.hex0", 32'(a_if.hex0), 32'(SZ));
        chk("abort.hex1", 32'(a_if.hex1), 32'(SZ));
        chk("abort.hex2", 32'(a_if.hex2), 32'(SZ));
        chk("abort.hex3", 32'(a_if.hex3), 32'(SZ));
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (a_if.done) seen++;
        end
        chk("abort.no_done", 32'(seen), 32'd0);
        $display("conv abort val=1500 done_pulses=%0d", seen);

        hv = '{0, 42, 0, 16'h0042, SZ, SZ, S4, S2, 0};
        convert(hv, 1'b0, "after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/score_bcd_display.md
Name: score_bcd_display

Overview:
- Downstream stage of the Snake score/high-score logic.
- Takes a binary score value and converts it to packed BCD with a sequential shift-add-3 (double-dabble) engine, so no combinational divide/modulo chain is needed.
- Encodes each digit for the board's active-low 7-segment HEX displays, with optional leading-zero blanking.
- Holds the last converted value between conversions; one conversion in flight at a time.

Parameters:
- SCORE_W, 11: width of the binary input value.
- NDIG, 4: number of BCD digits and HEX outputs produced. Fixed at 4 for port widths. Values of SCORE_W where 2^SCORE_W exceeds 9999 are legal (see overflow).

Ports:
- clk  input  1  system clock; all state on rising edge
- rst  input  1  synchronous, active-high reset
- value_in  input  SCORE_W  binary score to convert; sampled only on an accepted load
- load  input  1  conversion request; accepted only when busy=0
- blank_lz  input  1  1 = blank leading zero digits; sampled on the accepted load
- busy  output  1  high from the cycle after an accepted load through the DONE cycle
- done  output  1  one-cycle pulse; outputs updated in the same cycle
- ovf  output  1  last converted value exceeded 9999
- bcd  output  16  packed BCD, digit3 in [15:12] .. digit0 in [3:0]
- hex0, hex1, hex2, hex3  output  7 each  active-low segments {g,f,e,d,c,b,a}; hex0 = ones digit

Behaviour:
- Reset (clk edge with rst=1):
  - state=IDLE; busy=0, done=0, ovf=0, bcd=16'h0000.
  - hex0..hex3 = 7'b1000000 (digit "0").
  - Scratch registers cleared.
  - Reset has priority over everything, including mid-conversion: the conversion is aborted and no done pulse is produced.
- State machine IDLE -> SHIFT -> DONE -> IDLE.
- IDLE:
  - On load=1: capture value_in into shift register, blank_lz into a flag, and value_in > 9999 into an ovf flag.
  - Clear the BCD scratch, set bit counter = SCORE_W, go to SHIFT.
  - busy goes high the next cycle.
- SHIFT, one bit per cycle:
  - Every scratch nibble >= 5 gets +3, all nibbles in parallel.
  - Then {scratch, shift reg} shifts left by 1; the MSB of the value enters scratch bit 0.
  - Counter decrements. After SCORE_W shift cycles, go to DONE.
  - Scratch is 4*NDIG bits. Carries out of digit3 are discarded; this only matters when ovf is set.
- DONE, one cycle:
  - done=1. bcd, hex0..3 and ovf are registered from the scratch in this cycle.
  - If the ovf flag is set: bcd=16'h9999, all HEX show "9", ovf=1. Otherwise bcd=scratch and ovf=0.
  - Leading-zero blanking, when the flag is set: every digit above the highest nonzero digit shows 7'b1111111. hex0 is always shown, so a value of 0 shows "0".
  - Next state is IDLE.
- Latency: load accepted at edge N; done=1 and outputs valid after edge N+SCORE_W+1 (12 cycles for the default). Outputs are stable until the next DONE.
- load while busy=1, including the DONE cycle, is ignored and not queued. load in the first IDLE cycle after DONE is accepted.
- value_in changes after the load cycle have no effect on the current conversion.
- Segment codes (gfedcba, active low):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - Nibbles A-F cannot occur; encode them as all-off.
- done is never high for two consecutive cycles. busy=0 in IDLE only.

Test Plan:
- Reset, then load value 0 with blank_lz=0 -> done 12 cycles later; bcd=16'h0000; hex3..hex0 all 1000000; ovf=0.
- Load 2047 (max for 11 bits) with blank_lz=0 -> bcd=16'h2047; hex3=0100100, hex2=1000000, hex1=0011001, hex0=1111000; busy high for 12 cycles; single done pulse.
- Load 7 with blank_lz=1 -> hex3, hex2, hex1 = 1111111; hex0=1111000. Then load 1005 with blank_lz=1 -> bcd=16'h1005, no digits blanked (interior zeros shown).
- Load 123, then assert load with 999 on cycles 3 and 12 (DONE) -> only 123 is converted (bcd=16'h0123); load 999 in the following IDLE cycle -> bcd=16'h0999.
- Load 1500, assert rst at cycle 5 -> no done pulse; bcd=0, hex all "0", busy=0. A subsequent load of 42 completes normally with bcd=16'h0042.
- Instance with SCORE_W=14: load 12000 -> done after 15 cycles, ovf=1, bcd=16'h9999, all HEX 0010000. Then load 9999 -> ovf=0, bcd=16'h9999.
